// File: rtl/chan_mux_arb.sv
// chan_mux_arb -- N-channel to 1 multiplexer/arbiter with a registered output.
//
// Picks one input channel per cycle and loads its beat into a single output
// register. The output register doubles as a one-deep pipeline stage, so
// back-to-back beats flow at one per cycle when downstream is ready.
//
// Selection:
//   mode = 0 : fixed select; channel 'ctrl' is granted when it is valid.
//              A ctrl value that names no channel never grants.
//   mode = 1 : round-robin; search starts after the last granted channel,
//              wraps, and visits the last granted channel last.
//
// Optional feature (macro CHAN_MUX_LOCK_EN): adds port in_last. A beat with
// in_last=0 locks the grant onto its channel, in both modes, until that
// channel sends a beat with in_last=1. Without the macro every beat is
// arbitrated on its own.
//
// Ports:
//   clk        clock, all state updates on rising edge
//   rst        synchronous active-high reset
//   mode       0 = fixed select by ctrl, 1 = round-robin
//   ctrl       channel select for mode 0
//   in_data    packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_last    per-channel end-of-packet (CHAN_MUX_LOCK_EN only)
//   in_ready   per-channel ready, one-hot or zero
//   out_data   registered selected data
//   out_chan   channel that sourced out_data
//   out_valid  out_data holds an unconsumed beat
//   out_ready  downstream accepts the beat
module chan_mux_arb #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          ctrl,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
`ifdef CHAN_MUX_LOCK_EN
  input  logic [CHANNELS-1:0]       in_last,
`endif
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [SEL_W-1:0] last_grant;
  logic [SEL_W-1:0] grant;
  logic             grant_vld;
  logic [SEL_W-1:0] rr_idx;
  logic             load_en;
  logic             transfer;
  logic [WIDTH-1:0] sel_data;
  logic             locked;
  logic [SEL_W-1:0] lock_chan;

  // The output register can take a new beat when it is empty or being drained.
  assign load_en  = !out_valid || out_ready;
  assign transfer = grant_vld && load_en && !rst;

  // Grant selection.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    grant     = '0;
    grant_vld = 1'b0;
    rr_idx    = '0;
    if (locked) begin
      // A locked channel keeps the grant even while it is idle.
      grant     = lock_chan;
      grant_vld = in_valid[lock_chan];
    end else if (!mode) begin
      // Looping over real channels means an out-of-range ctrl matches nothing.
      for (int i = 0; i < CHANNELS; i++) begin
        if (ctrl == SEL_W'(i) && in_valid[i]) begin
          grant     = SEL_W'(i);
          grant_vld = 1'b1;
        end
      end
    end else begin
      // Walk offsets from farthest to nearest so the nearest valid channel
      // after last_grant is the final assignment; offset CHANNELS is
      // last_grant itself, which therefore has lowest priority.
      for (int k = CHANNELS; k >= 1; k--) begin
        rr_idx = SEL_W'((int'(last_grant) + k) % CHANNELS);
        if (in_valid[rr_idx]) begin
          grant     = rr_idx;
          grant_vld = 1'b1;
        end
      end
    end
  end

  // Data mux and ready decode.
  always_comb begin
    sel_data = '0;
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant == SEL_W'(i)) begin
        sel_data    = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = transfer;
      end
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      out_data   <= '0;
      out_chan   <= '0;
      out_valid  <= 1'b0;
      last_grant <= SEL_W'(CHANNELS - 1);
    end else if (transfer) begin
      out_data   <= sel_data;
      out_chan   <= grant;
      out_valid  <= 1'b1;
      last_grant <= grant;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

`ifdef CHAN_MUX_LOCK_EN
  // Lock tracking: a non-last beat pins the grant to its channel; the last
  // beat releases it. A last beat on an unlocked channel leaves it unlocked.
  always_ff @(posedge clk) begin
    if (rst) begin
      locked    <= 1'b0;
      lock_chan <= '0;
    end else if (transfer) begin
      locked    <= !in_last[grant];
      lock_chan <= grant;
    end
  end
`else
  assign locked    = 1'b0;
  assign lock_chan = '0;
`endif

endmodule

// File: tb/tb_chan_mux_arb.sv
// Self-checking bench for chan_mux_arb: directed scenarios followed by
// random stimulus, all compared against a cycle-level reference model.
// Builds with or without CHAN_MUX_LOCK_EN.
module tb_chan_mux_arb;

  localparam int W  = 32;
  localparam int CH = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          mode;
  logic [SW-1:0] ctrl;
  logic [CH*W-1:0] in_data;
  logic [CH-1:0] in_valid;
  logic [CH-1:0] in_ready;
  logic [W-1:0]  out_data;
  logic [SW-1:0] out_chan;
  logic          out_valid;
  logic          out_ready;
`ifdef CHAN_MUX_LOCK_EN
  logic [CH-1:0] in_last;
  logic [2:0]    in_last3;
`endif

  // Second instance with a non-power-of-two channel count.
  logic          rst3;
  logic          mode3;
  logic [1:0]    ctrl3;
  logic [23:0]   in_data3;
  logic [2:0]    in_valid3;
  logic [2:0]    in_ready3;
  logic [7:0]    out_data3;
  logic [1:0]    out_chan3;
  logic          out_valid3;
  logic          out_ready3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  chan_mux_arb #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW)) dut (
    .clk(clk), .rst(rst), .mode(mode), .ctrl(ctrl),
    .in_data(in_data), .in_valid(in_valid),
`ifdef CHAN_MUX_LOCK_EN
    .in_last(in_last),
`endif
    .in_ready(in_ready), .out_data(out_data), .out_chan(out_chan),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  chan_mux_arb #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst(rst3), .mode(mode3), .ctrl(ctrl3),
    .in_data(in_data3), .in_valid(in_valid3),
`ifdef CHAN_MUX_LOCK_EN
    .in_last(in_last3),
`endif
    .in_ready(in_ready3), .out_data(out_data3), .out_chan(out_chan3),
    .out_valid(out_valid3), .out_ready(out_ready3)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_ov;
  logic [W-1:0] m_od;
  int          m_oc;
  int          m_lg;
  bit          m_locked;
  int          m_lock;

  function automatic logic [W-1:0] chan_data(input int c);
    return in_data[c*W +: W];
  endfunction

  // Which channel wins this cycle, or -1 for none.
  function automatic int model_grant();
    if (m_locked) return in_valid[m_lock] ? m_lock : -1;
    if (mode == 1'b0) begin
      if (int'(ctrl) < CH && in_valid[ctrl]) return int'(ctrl);
      return -1;
    end
    for (int k = 1; k <= CH; k++) begin
      int c = (m_lg + k) % CH;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  // One clock cycle: check ready before the edge, advance the model, check outputs after.
  task automatic step();
    int g;
    bit load;
    logic [CH-1:0] exp_rdy;
    #1;
    g    = model_grant();
    load = !m_ov || out_ready;
    exp_rdy = (g >= 0 && load && !rst) ? CH'(1 << g) : '0;
    check("in_ready", in_ready, exp_rdy);
    @(posedge clk);
    if (rst) begin
      m_ov = 0; m_od = '0; m_oc = 0; m_lg = CH - 1; m_locked = 0; m_lock = 0;
    end else if (g >= 0 && load) begin
      m_od = chan_data(g);
      m_oc = g;
      m_ov = 1;
      m_lg = g;
`ifdef CHAN_MUX_LOCK_EN
      m_locked = !in_last[g];
      m_lock   = g;
`endif
    end else if (out_ready) begin
      m_ov = 0;
    end
    #1;
    check("out_valid", out_valid, m_ov);
    check("out_data", out_data, m_od);
    check("out_chan", out_chan, m_oc);
  endtask

  task automatic set_tagged_data();
    for (int i = 0; i < CH; i++) in_data[i*W +: W] = 32'hA5A5_0000 | W'(i);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  int seq_exp [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b1; mode = 1'b0; ctrl = '0; in_valid = '0; out_ready = 1'b0;
    in_data = '0;
`ifdef CHAN_MUX_LOCK_EN
    in_last = '1; in_last3 = '1;
`endif
    rst3 = 1'b1; mode3 = 1'b0; ctrl3 = 2'd0; in_valid3 = '0; out_ready3 = 1'b1;
    in_data3 = 24'h332211;
    m_ov = 0; m_od = '0; m_oc = 0; m_lg = CH - 1; m_locked = 0; m_lock = 0;

    // Reset state.
    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    rst3 = 1'b0;

    // Fixed select of channel 2 with all channels valid.
    set_tagged_data();
    mode = 1'b0; ctrl = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
    #1;
    check("fix_ready_onehot", in_ready, 4'b0100);
    step();
    check("fix_data", out_data, 32'hA5A5_0002);
    check("fix_chan", out_chan, 2);

    // Three-channel instance: ctrl naming a missing channel never grants.
    mode3 = 1'b0; ctrl3 = 2'd3; in_valid3 = 3'b111;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("c3_ready_none", in_ready3, 3'b000);
      @(posedge clk); #1;
      check("c3_out_valid", out_valid3, 0);
    end
    ctrl3 = 2'd2;
    #1;
    check("c3_ready_ch2", in_ready3, 3'b100);
    @(posedge clk); #1;
    check("c3_data_ch2", out_data3, 8'h33);

    // Round-robin sweep after reset: 0,1,2,3,0 back to back.
    do_reset();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr_seq_chan", out_chan, seq_exp[i]);
      check("rr_seq_valid", out_valid, 1);
    end

    // Stall for three cycles, then resume with the next channel.
    do_reset();
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_ready", in_ready, 4'b0000);
      step();
      check("stall_chan", out_chan, 0);
      check("stall_data", out_data, 32'hA5A5_0000);
    end
    out_ready = 1'b1;
    step();
    check("resume_chan", out_chan, 1);

    // Reset while stalled drops the beat; next grant restarts at channel 0.
    out_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("rst_stall_valid", out_valid, 0);
    check("rst_stall_data", out_data, 0);
    check("rst_stall_chan", out_chan, 0);
    rst = 1'b0; out_ready = 1'b1;
    step();
    check("post_rst_chan", out_chan, 0);

`ifdef CHAN_MUX_LOCK_EN
    // Packet lock: channel 1 sends last=0,0,1, channel 3 waits.
    do_reset();
    mode = 1'b1; in_valid = 4'b1010; out_ready = 1'b1;
    in_last = 4'b1000;
    step(); check("lock_b0", out_chan, 1);
    step(); check("lock_b1", out_chan, 1);
    in_last = 4'b1010;
    step(); check("lock_b2", out_chan, 1);
    step(); check("lock_after", out_chan, 3);
    // Locked channel idle: nobody else gets ready.
    in_last = 4'b0000; in_valid = 4'b0010;
    step();
    in_valid = 4'b1101;
    #1;
    check("lock_idle_ready", in_ready, 4'b0000);
    step();
`endif

    // Random stimulus.
    for (int n = 0; n < 800; n++) begin
      rst       = ($urandom_range(0, 49) == 0);
      mode      = 1'($urandom);
      ctrl      = SW'($urandom);
      in_valid  = CH'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < CH; i++) in_data[i*W +: W] = $urandom;
`ifdef CHAN_MUX_LOCK_EN
      in_last   = CH'($urandom);
`endif
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chan_mux_arb.md
CHAN_MUX_ARB -- requirements
Module: chan_mux_arb

Interface
REQ-001 Parameter WIDTH, default 32, data width per channel in bits (1..64).
REQ-002 Parameter CHANNELS, default 4, number of input channels (2..16).
REQ-003 Parameter SEL_W, default 2, select width; SHALL equal ceil(log2(CHANNELS)).
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port mode  input  1  0 = fixed select by ctrl; 1 = round-robin arbitration.
REQ-007 Port ctrl  input  SEL_W  channel select used when mode=0.
REQ-008 Port in_data  input  CHANNELS*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 Port in_valid  input  CHANNELS  per-channel valid.
REQ-010 Port in_ready  output  CHANNELS  per-channel ready; at most one bit high per cycle.
REQ-011 Port out_data  output  WIDTH  registered selected data.
REQ-012 Port out_chan  output  SEL_W  channel index that sourced out_data.
REQ-013 Port out_valid  output  1  out_data holds an unconsumed beat.
REQ-014 Port out_ready  input  1  downstream accepts the beat when high with out_valid.

Function
REQ-015 Beat transfer on channel i SHALL occur when in_valid[i] and in_ready[i] are both high at a rising edge.
REQ-016 load_en SHALL be (!out_valid || out_ready); in_ready SHALL be zero while load_en is low.
REQ-017 Mode 0: grant = ctrl when ctrl < CHANNELS and in_valid[ctrl]=1; otherwise no grant; ctrl >= CHANNELS SHALL never grant.
REQ-018 Mode 1: grant = first channel with in_valid high, searching from last_grant+1 upward and wrapping CHANNELS-1 -> 0; last_grant itself is searched last.
REQ-019 in_ready[grant] SHALL be high only when a grant exists and load_en is high; in_ready is combinational from in_valid, mode, ctrl, out_valid, out_ready and state.
REQ-020 On transfer: out_data <= granted channel data, out_chan <= grant, out_valid <= 1, last_grant <= grant; latency in_valid to out_valid is exactly 1 cycle.
REQ-021 When out_valid && out_ready and no new transfer: out_valid <= 0; out_data and out_chan hold.
REQ-022 Simultaneous consume and transfer SHALL sustain one beat per cycle with no bubble.
REQ-023 While out_valid && !out_ready: out_data, out_chan, out_valid, last_grant SHALL hold; no channel acknowledged.
REQ-024 last_grant SHALL update only on a transfer, in either mode.
REQ-025 mode or ctrl changes SHALL take effect on the next grant evaluation; a held output beat is unaffected.

Reset
REQ-026 While rst is high at a rising edge: out_valid=0, out_data=0, out_chan=0, last_grant=CHANNELS-1, lock state cleared; in_ready SHALL be all zero during that cycle.
REQ-027 Reset mid-stall SHALL discard the held beat; the first round-robin grant after reset SHALL search from channel 0.

Configuration
REQ-028 Macro CHAN_MUX_LOCK_EN defined: extra input port in_last (CHANNELS bits); after a transfer on channel i with in_last[i]=0, grant SHALL be locked to channel i in both modes until a transfer on i with in_last[i]=1; while locked, other channels get no ready even if channel i is not valid.
REQ-029 Macro CHAN_MUX_LOCK_EN undefined: in_last port absent; every beat arbitrated independently per REQ-017/018.
REQ-030 With lock enabled, a beat with in_last=1 on an unlocked channel SHALL not create a lock; reset SHALL clear any lock.

Verification
REQ-031 Mode 0, ctrl=2, in_valid=4'b1111, channel 2 data=0xA5A5_0002, out_ready=1 -> next cycle out_data=0xA5A5_0002, out_chan=2, out_valid=1, only in_ready[2] high.
REQ-032 Mode 1, all four valid, out_ready=1, after reset -> out_chan sequence 0,1,2,3,0 on consecutive cycles, one beat per cycle.
REQ-033 Mode 1, beat held with out_ready=0 for 3 cycles -> out_data/out_chan stable, in_ready=0 all 3 cycles; on out_ready=1 next channel granted with no bubble.
REQ-034 Mode 0, CHANNELS=3, ctrl=3, in_valid=3'b111 -> in_ready=0, out_valid stays 0.
REQ-035 rst asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_data=0, out_chan=0; next mode-1 grant is channel 0.
REQ-036 CHAN_MUX_LOCK_EN defined, mode 1, channels 1 and 3 valid, channel 1 sends beats with in_last=0,0,1 -> out_chan=1,1,1 then 3; channel 3 not ready until the in_last=1 beat transfers.
